systolic_seq_ctrl: RTL

//  Sequencer for the 2x2 systolic array: configures column enables, loads weights,

---
 rtl/systolic_seq_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the 2x2 systolic array: column config, weight load, switch, skewed row streaming, result drain.
// Optional drain watchdog: define SYS_SEQ_TIMEOUT_EN.
module systolic_seq_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ROWS_W    = 16,
  parameter int DRAIN_TMO = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_cols,
  input  logic [ROWS_W-1:0] cmd_rows,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data_0,
  input  logic [DATA_W-1:0] w_data_1,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [DATA_W-1:0] x_data_0,
  input  logic [DATA_W-1:0] x_data_1,
  output logic [DATA_W-1:0] sys_weight_in_x1,
  output logic [DATA_W-1:0] sys_weight_in_x2,
  output logic              sys_accept_w_1,
  output logic              sys_accept_w_2,
  output logic              sys_switch_in,
  output logic [DATA_W-1:0] sys_data_in_1x,
  output logic [DATA_W-1:0] sys_data_in_2x,
  output logic              sys_start,
  output logic [15:0]       ub_rd_col_size_in,
  output logic              ub_rd_col_size_valid_in,
  input  logic              sys_valid_out_x1,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // state    | meaning
  // IDLE     | waiting for a job, cmd_ready high
  // CFG      | column-count strobe to the array (skipped strobe when cols==0)
  // LOAD_W   | accepting two weight rows
  // SWITCH   | weights complete, switch pulse issued next cycle
  // STREAM   | issuing input rows, counting results
  // DRAIN    | all rows issued, waiting for remaining results
  // DONE     | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_LOAD_W, S_SWITCH, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [1:0]        cols_q, cols_d;
  logic [ROWS_W-1:0] rows_q, rows_d;
  logic [ROWS_W-1:0] issued_q, issued_d;
  logic [ROWS_W-1:0] recv_q, recv_d;
  logic              wbeat_q, wbeat_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] wt1_q, wt1_d, wt2_q, wt2_d;
  logic              acc1_q, acc1_d, acc2_q, acc2_d;
  logic              sw_q, sw_d;
  logic [DATA_W-1:0] d1_q, d1_d, skew_q, skew_d, d2_q, d2_d;
  logic              start_q, start_d;

  logic x_rdy, x_hs, w_hs, r_cnt, tmo_hit;

`ifdef SYS_SEQ_TIMEOUT_EN
  localparam logic [31:0] TMO = 32'(DRAIN_TMO);
  // idle_q = cycles since the last result (or since entering DRAIN)
  logic [31:0] idle_q, idle_d;
  assign tmo_hit = !sys_valid_out_x1 && (idle_q + 32'd1 == TMO);
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(DRAIN_TMO);
  assign tmo_hit    = 1'b0;
`endif

  assign w_hs  = (state_q == S_LOAD_W) && w_valid;
  assign x_rdy = (state_q == S_STREAM) && (issued_q < rows_q);
  assign x_hs  = x_rdy && x_valid;
  assign r_cnt = ((state_q == S_STREAM) || (state_q == S_DRAIN)) &&
                 sys_valid_out_x1 && (recv_q < rows_q);

  always_comb begin
    state_d  = state_q;
    cols_d   = cols_q;
    rows_d   = rows_q;
    issued_d = issued_q;
    recv_d   = recv_q;
    wbeat_d  = wbeat_q;
    err_d    = err_q;
    wt1_d    = wt1_q;
    wt2_d    = wt2_q;
    acc1_d   = 1'b0;
    acc2_d   = 1'b0;
    sw_d     = 1'b0;
    d1_d     = '0;
    skew_d   = '0;
    d2_d     = skew_q;
    start_d  = 1'b0;
`ifdef SYS_SEQ_TIMEOUT_EN
    idle_d   = 32'd0;
`endif
    if (r_cnt) recv_d = recv_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cols_d   = (cmd_cols == 2'd3) ? 2'd2 : cmd_cols;
          rows_d   = cmd_rows;
          issued_d = '0;
          recv_d   = '0;
          wbeat_d  = 1'b0;
          err_d    = 1'b0;
          state_d  = S_CFG;
        end
      end
      S_CFG: begin
        if (cols_q == 2'd0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (w_hs) begin
          wt1_d   = w_data_0;
          wt2_d   = w_data_1;
          acc1_d  = 1'b1;
          acc2_d  = (cols_q == 2'd2);
          wbeat_d = 1'b1;
          if (wbeat_q) state_d = S_SWITCH;
        end
      end
      S_SWITCH: begin
        sw_d    = 1'b1;
        state_d = (rows_q == '0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
`ifdef SYS_SEQ_TIMEOUT_EN
        idle_d = sys_valid_out_x1 ? 32'd1 : 32'd0;
`endif
        if (x_hs) begin
          d1_d     = x_data_0;
          skew_d   = x_data_1;
          start_d  = 1'b1;
          issued_d = issued_q + 1'b1;
          if (issued_q == rows_q - 1'b1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
`ifdef SYS_SEQ_TIMEOUT_EN
        idle_d = sys_valid_out_x1 ? 32'd1 : idle_q + 32'd1;
`endif
        if (recv_q == rows_q) begin
          state_d = S_DONE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cols_q   <= '0;
      rows_q   <= '0;
      issued_q <= '0;
      recv_q   <= '0;
      wbeat_q  <= 1'b0;
      err_q    <= 1'b0;
      wt1_q    <= '0;
      wt2_q    <= '0;
      acc1_q   <= 1'b0;
      acc2_q   <= 1'b0;
      sw_q     <= 1'b0;
      d1_q     <= '0;
      skew_q   <= '0;
      d2_q     <= '0;
      start_q  <= 1'b0;
`ifdef SYS_SEQ_TIMEOUT_EN
      idle_q   <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      cols_q   <= cols_d;
      rows_q   <= rows_d;
      issued_q <= issued_d;
      recv_q   <= recv_d;
      wbeat_q  <= wbeat_d;
      err_q    <= err_d;
      wt1_q    <= wt1_d;
      wt2_q    <= wt2_d;
      acc1_q   <= acc1_d;
      acc2_q   <= acc2_d;
      sw_q     <= sw_d;
      d1_q     <= d1_d;
      skew_q   <= skew_d;
      d2_q     <= d2_d;
      start_q  <= start_d;
`ifdef SYS_SEQ_TIMEOUT_EN
      idle_q   <= idle_d;
`endif
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign w_ready   = (state_q == S_LOAD_W);
  assign x_ready   = x_rdy;
  assign done      = (state_q == S_DONE);
  assign err       = done && err_q;

  // a zero-column job never touches the array, so no strobe either
  assign ub_rd_col_size_valid_in = (state_q == S_CFG) && (cols_q != 2'd0);
  assign ub_rd_col_size_in       = (state_q == S_CFG) ? {14'd0, cols_q} : 16'd0;

  assign sys_weight_in_x1 = wt1_q;
  assign sys_weight_in_x2 = wt2_q;
  assign sys_accept_w_1   = acc1_q;
  assign sys_accept_w_2   = acc2_q;
  assign sys_switch_in    = sw_q;
  assign sys_data_in_1x   = d1_q;
  assign sys_data_in_2x   = d2_q;
  assign sys_start        = start_q;

endmodule
